dcache_mem_arbiter: RTL and testbench

- Shares the single OBI-style data memory port between two requesters on the data side: port 0 is the cache refill/load-miss path; port 1 is the write-through store path.
- Selects the winning requester and holds the address phase stable until granted.
- Tracks outstanding transactions in order and routes each rvalid/rdata back to the requester that issued it.
- Sits between the data cache and the data memory (or bus) interface of the core.

---
 rtl/dcache_arb_pkg.sv | 23 ++
 rtl/dcache_arb_id_fifo.sv | 54 +++++
 rtl/dcache_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_dcache_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_arb_pkg.sv
// Shared types and helpers for the data-side memory arbiter.
// Port identifiers, the arbiter lock state, and FIFO pointer sizing.
package dcache_arb_pkg;

   typedef logic port_id_t;

   localparam port_id_t PORT_REFILL = 1'b0;
   localparam port_id_t PORT_STORE  = 1'b1;
   localparam int       NUM_PORTS   = 2;

   // ARB_LOCKED: an address phase was offered but not yet granted, so the
   // selection is frozen on lock_id until the memory grants it.
   typedef enum logic {
      ARB_OPEN   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   // Bits needed to index 'depth' entries (at least one bit).
   function automatic int fifo_ptr_width(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/dcache_arb_id_fifo.sv
// In-order FIFO of port ids for accepted-but-unanswered transactions.
// A push while full and a pop while empty are ignored.
module dcache_arb_id_fifo
   import dcache_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push_i,
   input  port_id_t id_i,
   input  logic     pop_i,
   output logic     full_o,
   output logic     empty_o,
   output port_id_t head_o
);

   localparam int PTR_W = fifo_ptr_width(DEPTH);
   localparam int CNT_W = fifo_ptr_width(DEPTH + 1);

   port_id_t           slots_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic               do_push, do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = slots_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Storage, pointers and occupancy; push and pop may coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) slots_q[i] <= PORT_REFILL;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            slots_q[wr_ptr_q] <= id_i;
            wr_ptr_q          <= next_ptr(wr_ptr_q);
         end
         if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
         if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
         else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/dcache_mem_arbiter.sv
// Shares one OBI-style data memory port between the refill path (port 0)
// and the write-through store path (port 1). Round-robin arbitration with
// address-phase locking until grant; responses are routed back in order.
// Build option: DCACHE_ARB_FIXED_PRIO_EN gives port 0 fixed priority and
// removes the round-robin pointer.
// Handshake: a port's transaction is accepted in the cycle where req_i and
// gnt_o are both 1; once offered to memory, the address phase stays stable
// until mem_gnt_i. rvalid_o is a one-cycle pulse qualifying rdata_o.
module dcache_mem_arbiter
   import dcache_arb_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic [NUM_PORTS-1:0]                       req_i,
   input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]       addr_i,
   input  logic [NUM_PORTS-1:0]                       we_i,
   input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]     be_i,
   input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]       wdata_i,
   output logic [NUM_PORTS-1:0]                       gnt_o,
   output logic [NUM_PORTS-1:0]                       rvalid_o,
   output logic [DATA_WIDTH-1:0]                      rdata_o,
   output logic                                       mem_req_o,
   output logic [ADDR_WIDTH-1:0]                      mem_addr_o,
   output logic                                       mem_we_o,
   output logic [DATA_WIDTH/8-1:0]                    mem_be_o,
   output logic [DATA_WIDTH-1:0]                      mem_wdata_o,
   input  logic                                       mem_gnt_i,
   input  logic                                       mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]                      mem_rdata_i,
   output logic                                       busy_o
);

   arb_state_e state_q;
   port_id_t   lock_id_q;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
   port_id_t   rr_ptr_q;
`endif
   port_id_t   sel;
   port_id_t   fifo_head;
   logic       fifo_full, fifo_empty;
   logic       accept, resp_pop;

   // Winner selection: frozen while locked, otherwise priority rule.
   always_comb begin
      sel = PORT_REFILL;
      if (state_q == ARB_LOCKED) sel = lock_id_q;
`ifdef DCACHE_ARB_FIXED_PRIO_EN
      else if (req_i[PORT_REFILL]) sel = PORT_REFILL;
      else                         sel = PORT_STORE;
`else
      else if (req_i[rr_ptr_q])    sel = rr_ptr_q;
      else if (req_i[~rr_ptr_q])   sel = ~rr_ptr_q;
      else                         sel = rr_ptr_q;
`endif
   end

   assign mem_req_o   = (|req_i) && !fifo_full;
   assign mem_addr_o  = addr_i[sel];
   assign mem_we_o    = we_i[sel];
   assign mem_be_o    = be_i[sel];
   assign mem_wdata_o = wdata_i[sel];
   assign accept      = mem_req_o && mem_gnt_i;
   assign resp_pop    = mem_rvalid_i && !fifo_empty;
   assign rdata_o     = mem_rdata_i;
   assign busy_o      = (state_q == ARB_LOCKED) || !fifo_empty;

   // Grant and response steering to the owning port.
   always_comb begin
      gnt_o    = '0;
      rvalid_o = '0;
      if (accept)   gnt_o[sel]          = 1'b1;
      if (resp_pop) rvalid_o[fifo_head] = 1'b1;
   end

   // Lock state machine and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ARB_OPEN;
         lock_id_q <= PORT_REFILL;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
         rr_ptr_q  <= PORT_REFILL;
`endif
      end else if (accept) begin
         state_q   <= ARB_OPEN;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
         rr_ptr_q  <= ~sel;
`endif
      end else if (mem_req_o) begin
         state_q   <= ARB_LOCKED;
         lock_id_q <= sel;
      end
   end

   dcache_arb_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (accept),
      .id_i    (sel),
      .pop_i   (resp_pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head)
   );

`ifndef SYNTHESIS
   a_resp_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
      mem_rvalid_i |-> !fifo_empty)
      else $warning("dcache_mem_arbiter: response with nothing outstanding was dropped");

   a_locked_req_held: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == ARB_LOCKED) |-> req_i[lock_id_q])
      else $warning("dcache_mem_arbiter: locked port withdrew its request");
`endif

endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// Bench for dcache_mem_arbiter: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a queue-based
// model of the arbitration, locking and in-order response rules.
// Honors DCACHE_ARB_FIXED_PRIO_EN the same way as the design.
module tb_dcache_mem_arbiter;
   import dcache_arb_pkg::*;

   localparam int MAX_OUT = 2;
   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int BW      = DW / 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [1:0]         req_i = '0;
   logic [1:0][AW-1:0] addr_i = '0;
   logic [1:0]         we_i = '0;
   logic [1:0][BW-1:0] be_i = '0;
   logic [1:0][DW-1:0] wdata_i = '0;
   logic [1:0]         gnt_o, rvalid_o;
   logic [DW-1:0]      rdata_o;
   logic               mem_req_o, mem_we_o, busy_o;
   logic [AW-1:0]      mem_addr_o;
   logic [BW-1:0]      mem_be_o;
   logic [DW-1:0]      mem_wdata_o;
   logic               mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
   logic [DW-1:0]      mem_rdata_i = '0;

   int checks = 0;
   int errors = 0;

   // Model: owners of outstanding transactions in issue order, plus the
   // pending-offer hold and which port has round-robin priority.
   logic [0:0] exp_q[$];
   logic       m_lock = 1'b0, m_lock_id = 1'b0, m_prio = 1'b0;
   logic [1:0] m_gnt_last = '0;
   logic       win, e_req;
   logic [1:0] e_gnt, e_rv;

   always #5 clk = ~clk;

   dcache_mem_arbiter #(
      .MAX_OUTSTANDING (MAX_OUT),
      .ADDR_WIDTH      (AW),
      .DATA_WIDTH      (DW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_i        (req_i),
      .addr_i       (addr_i),
      .we_i         (we_i),
      .be_i         (be_i),
      .wdata_i      (wdata_i),
      .gnt_o        (gnt_o),
      .rvalid_o     (rvalid_o),
      .rdata_o      (rdata_o),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .busy_o       (busy_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: inputs are stable at the falling edge, so evaluate
   // the model's expected outputs, compare, then apply the rising-edge effect.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         m_lock = 1'b0;
         m_lock_id = 1'b0;
         m_prio = 1'b0;
         m_gnt_last = '0;
      end
      e_req = (|req_i) && (exp_q.size() < MAX_OUT);
      if (m_lock) win = m_lock_id;
`ifdef DCACHE_ARB_FIXED_PRIO_EN
      else win = req_i[0] ? 1'b0 : 1'b1;
`else
      else if (req_i[m_prio]) win = m_prio;
      else if (req_i[!m_prio]) win = !m_prio;
      else win = m_prio;
`endif
      e_gnt = (e_req && mem_gnt_i) ? (2'b01 << win) : 2'b00;
      e_rv  = (mem_rvalid_i && exp_q.size() > 0) ? (2'b01 << exp_q[0]) : 2'b00;
      chk("mem_req", mem_req_o, e_req);
      chk("gnt", gnt_o, e_gnt);
      chk("rvalid", rvalid_o, e_rv);
      chk("busy", busy_o, m_lock || exp_q.size() > 0);
      if (e_req) begin
         chk("mem_addr", mem_addr_o, addr_i[win]);
         chk("mem_we", mem_we_o, we_i[win]);
         chk("mem_be", mem_be_o, be_i[win]);
         chk("mem_wdata", mem_wdata_o, wdata_i[win]);
      end
      if (|e_rv) chk("rdata", rdata_o, mem_rdata_i);
      if (rst_n) begin
         if (|e_rv) void'(exp_q.pop_front());
         if (|e_gnt) begin
            exp_q.push_back(win);
            m_lock = 1'b0;
            m_prio = !win;
         end else if (e_req) begin
            m_lock = 1'b1;
            m_lock_id = win;
         end
         m_gnt_last = e_gnt;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic r, input logic [AW-1:0] a,
                           input logic w, input logic [DW-1:0] d);
      req_i[p]   = r;
      addr_i[p]  = a;
      we_i[p]    = w;
      be_i[p]    = 4'hF;
      wdata_i[p] = d;
   endtask

   task automatic quiet();
      req_i = '0;
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
   endtask

   initial begin
      // Reset
      repeat (2) step();
      chk("rst_mem_req_lit", mem_req_o, 0);
      chk("rst_busy_lit", busy_o, 0);
      rst_n = 1'b1;
      step();

      // Single-port refill
      set_port(0, 1, 32'h0000_0100, 0, 0);
      mem_gnt_i = 1;
      #1 chk("refill_gnt_lit", gnt_o, 2'b01);
      step(); quiet();
      #1 chk("refill_gnt_off_lit", gnt_o, 2'b00);
      step(); mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
      #1 chk("refill_rvalid_lit", rvalid_o, 2'b01);
      chk("refill_rdata_lit", rdata_o, 32'hDEAD_BEEF);
      step(); quiet();

      // Order routing
      set_port(0, 1, 32'h0000_0400, 0, 0); mem_gnt_i = 1;
      step(); set_port(0, 0, 0, 0, 0); set_port(1, 1, 32'h0000_0500, 1, 32'h55);
      #1 chk("order_gnt1_lit", gnt_o, 2'b10);
      step(); quiet(); mem_rvalid_i = 1; mem_rdata_i = 32'h1111_1111;
      #1 chk("order_rv0_lit", rvalid_o, 2'b01);
      chk("order_rd0_lit", rdata_o, 32'h1111_1111);
      step(); mem_rdata_i = 32'h2222_2222;
      #1 chk("order_rv1_lit", rvalid_o, 2'b10);
      chk("order_rd1_lit", rdata_o, 32'h2222_2222);
      step(); quiet();

      // Contention
      set_port(0, 1, 32'h0000_0600, 0, 0);
      set_port(1, 1, 32'h0000_0700, 1, 32'h77);
      mem_gnt_i = 1;
      for (int i = 0; i < 6; i++) begin
         mem_rvalid_i = (i > 0);
         #1;
`ifdef DCACHE_ARB_FIXED_PRIO_EN
         chk("contend_gnt_lit", gnt_o, 2'b01);
`else
         chk("contend_gnt_lit", gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
`endif
         step();
      end
      quiet(); mem_rvalid_i = 1;
      step(); quiet();

      // Lock stability
      set_port(1, 1, 32'h0000_0200, 1, 32'hCAFE);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) set_port(0, 1, 32'h0000_0300, 0, 0);
         #1 chk("lock_addr_lit", mem_addr_o, 32'h0000_0200);
         chk("lock_we_lit", mem_we_o, 1);
         step();
      end
      mem_gnt_i = 1;
      #1 chk("lock_first_lit", gnt_o, 2'b10);
      step(); req_i[1] = 0;
      #1 chk("lock_second_lit", gnt_o, 2'b01);
      step(); quiet(); mem_rvalid_i = 1;
      #1 chk("lock_rv1_lit", rvalid_o, 2'b10);
      step();
      #1 chk("lock_rv0_lit", rvalid_o, 2'b01);
      step(); quiet();

      // Outstanding limit
      set_port(0, 1, 32'h0000_0800, 0, 0); mem_gnt_i = 1;
      #1 chk("lim_g1_lit", gnt_o, 2'b01);
      step();
      #1 chk("lim_g2_lit", gnt_o, 2'b01);
      step();
      #1 chk("lim_full_req_lit", mem_req_o, 0);
      step(); mem_rvalid_i = 1;
      #1 chk("lim_pop_rv_lit", rvalid_o, 2'b01);
      chk("lim_pop_req_lit", mem_req_o, 0);
      step(); mem_rvalid_i = 0;
      #1 chk("lim_next_gnt_lit", gnt_o, 2'b01);
      step(); quiet(); mem_rvalid_i = 1;
      step(); step(); quiet();

      // Reset mid-flight
      set_port(0, 1, 32'h0000_0900, 0, 0); mem_gnt_i = 1;
      step(); quiet(); rst_n = 0;
      #1 chk("rst_mid_busy_lit", busy_o, 0);
      chk("rst_mid_gnt_lit", gnt_o, 0);
      step(); rst_n = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h3333_3333;
      #1 chk("rst_late_rv_lit", rvalid_o, 0);
      chk("rst_late_busy_lit", busy_o, 0);
      step(); quiet();

      // Randomized traffic; a requester holds its request until granted
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (!req_i[p] || m_gnt_last[p])
               set_port(p, $urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 1), $urandom);
            be_i[p] = (!req_i[p] || m_gnt_last[p]) ? BW'($urandom) : be_i[p];
         end
         mem_gnt_i    = $urandom_range(0, 99) < 60;
         mem_rvalid_i = (exp_q.size() > 0) && ($urandom_range(0, 99) < 50);
         mem_rdata_i  = $urandom;
         step();
      end

      // Let held requests complete, then drain responses
      mem_gnt_i = 1; mem_rvalid_i = 0;
      step();
      for (int i = 0; i < 3 && (m_gnt_last != 0 || req_i != 0); i++) begin
         for (int p = 0; p < 2; p++) if (m_gnt_last[p]) req_i[p] = 0;
         mem_gnt_i = 1;
         mem_rvalid_i = 0;
         step();
      end
      quiet();
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         mem_rvalid_i = 1;
         step();
      end
      quiet();
      #1 chk("drain_busy", busy_o, 0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
